// File: rtl/inst_loader.sv
// Boot-time program loader: parses a length-prefixed big-endian byte stream,
// writes each assembled 32-bit word to instruction memory, and holds the core in reset until done.
module inst_loader #(
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_adr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] nwords_q, nwords_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic [15:0] words_q, words_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] len_w;
    logic        xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LEN_HI;
            nwords_q <= 16'd0;
            bcnt_q   <= 2'd0;
            shift_q  <= 24'd0;
            words_q  <= 16'd0;
            adr_q    <= BASE_ADR;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            nwords_q <= nwords_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            words_q  <= words_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nwords_d = nwords_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        words_d  = words_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        xfer     = in_valid && in_ready;
        len_w    = {nwords_q[15:8], in_data};

        case (state_q)
            S_LEN_HI: if (xfer) begin
                nwords_d = {in_data, 8'd0};
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                nwords_d = len_w;
                if (len_w == 16'd0)
                    state_d = S_DONE;
                else if ({1'b0, len_w} > MAX_W)
                    state_d = S_ERR;
                else
                    state_d = S_DATA;
            end
            S_DATA: if (xfer) begin
                shift_d = {shift_q[15:0], in_data};
                bcnt_d  = bcnt_q + 2'd1;
                // Word and address are registered here so they are stable for the whole WRITE cycle.
                if (bcnt_q == 2'd3) begin
                    wdata_d = {shift_q, in_data};
                    adr_d   = BASE_ADR + {14'd0, words_q, 2'b00};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_q == nwords_q - 16'd1) ? S_DONE : S_DATA;
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs are forced to their reset values during the rst cycle itself, not only after it.
    assign in_ready     = !rst && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA);
    assign im_we        = !rst && (state_q == S_WRITE);
    assign im_adr       = rst ? BASE_ADR : adr_q;
    assign im_wdata     = rst ? 32'd0 : wdata_q;
    assign cpu_rst      = rst || (state_q != S_DONE);
    assign done         = !rst && (state_q == S_DONE);
    assign err          = !rst && (state_q == S_ERR);
    assign words_loaded = rst ? 16'd0 : words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader: dut0 uses BASE_ADR=0, dut1 uses BASE_ADR=0x100.
module tb_inst_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst1 = 1'b1;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = 8'd0;
    bit         sel = 1'b0;

    logic        v0, v1, rdy0, rdy1, we0, we1, crst0, crst1, done0, done1, err0, err1;
    logic [31:0] adr0, adr1, wdat0, wdat1;
    logic [15:0] wl0, wl1;

    assign v0 = tb_valid & ~sel;
    assign v1 = tb_valid & sel;

    inst_loader dut0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_data(tb_data), .in_ready(rdy0),
        .im_we(we0), .im_adr(adr0), .im_wdata(wdat0), .cpu_rst(crst0),
        .done(done0), .err(err0), .words_loaded(wl0)
    );

    inst_loader #(.BASE_ADR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_data(tb_data), .in_ready(rdy1),
        .im_we(we1), .im_adr(adr1), .im_wdata(wdat1), .cpu_rst(crst1),
        .done(done1), .err(err1), .words_loaded(wl1)
    );

    int tests_run = 0, tests_failed = 0;
    int cyc = 0, start_cyc = 0, done_cyc0 = -1, done_cyc1 = -1, last_we0 = -1;
    int bad_ready = 0, both_bad = 0, offered = 0, left = 0;
    logic [7:0]  stream[$];
    logic [31:0] wa0[$], wd0[$], wa1[$];

    // One cycle: advance to the falling edge and log what both DUTs show there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (we0) begin
            wa0.push_back(adr0);
            wd0.push_back(wdat0);
            last_we0 = cyc;
            if (rdy0) bad_ready++;
        end
        if (we1) begin
            wa1.push_back(adr1);
            if (rdy1) bad_ready++;
        end
        if (done0 && done_cyc0 < 0) done_cyc0 = cyc;
        if (done1 && done_cyc1 < 0) done_cyc1 = cyc;
        if ((done0 && err0) || (done1 && err1)) both_bad++;
    endtask

    task automatic clear_log();
        wa0.delete(); wd0.delete(); wa1.delete();
        done_cyc0 = -1; done_cyc1 = -1; last_we0 = -1;
        bad_ready = 0; both_bad = 0; offered = 0;
    endtask

    task automatic do_reset0();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        clear_log();
        step();
    endtask

    task automatic load_basic();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    endtask

    // Presents the queued bytes to the selected DUT; rnd toggles in_valid but always offers during WRITE.
    task automatic drive_stream(input bit rnd, input int maxc, output int remaining);
        bit acc = 1'b0;
        bit first = 1'b1;
        int n = 0;
        forever begin
            step();
            if (acc) void'(stream.pop_front());
            acc = 1'b0;
            if (stream.size() == 0 || n >= maxc) break;
            tb_data  = stream[0];
            tb_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && (sel ? we1 : we0)) begin
                tb_valid = 1'b1;
                offered++;
            end
            #1;
            acc = tb_valid && (sel ? rdy1 : rdy0);
            if (acc && first) begin
                start_cyc = cyc;
                first = 1'b0;
            end
            n++;
        end
        tb_valid = 1'b0;
        remaining = stream.size();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(sel ? done1 : done0) && n < 40) begin
            step();
            n++;
        end
        tests_run++;
        if (!(sel ? done1 : done0)) begin
            tests_failed++;
            $display("[TB] FAIL %s_timeout: done never rose within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        step();
        tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ready: got %b want 0", rdy0); end
        tests_run++; if (we0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_we: got %b want 0", we0); end
        tests_run++; if (adr0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_adr0: got %h want 0", adr0); end
        tests_run++; if (adr1 !== 32'h100) begin tests_failed++; $display("[TB] FAIL rst_adr1: got %h want 100", adr1); end
        tests_run++; if (wdat0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_wdata: got %h want 0", wdat0); end
        tests_run++; if (crst0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_cpu_rst: got %b want 1", crst0); end
        tests_run++; if (done0 !== 1'b0 || err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_done_err: got %b%b want 00", done0, err0); end
        tests_run++; if (wl0 !== 16'd0) begin tests_failed++; $display("[TB] FAIL rst_words: got %0d want 0", wl0); end
        rst0 = 1'b0;
        clear_log();
        step();
        tests_run++; if (rdy0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_rst_ready: got %b want 1", rdy0); end
        tests_run++; if (crst0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_rst_cpu_rst: got %b want 1", crst0); end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        load_basic();
        drive_stream(1'b0, 200, left);
        wait_done("basic");
        tests_run++; if (wa0.size() != 2) begin tests_failed++; $display("[TB] FAIL basic_nwrites: got %0d want 2", wa0.size()); end
        tests_run++; if (wa0[0] !== 32'h0 || wd0[0] !== 32'h20080005) begin tests_failed++; $display("[TB] FAIL basic_w0: got %h/%h want 0/20080005", wa0[0], wd0[0]); end
        tests_run++; if (wa0[1] !== 32'h4 || wd0[1] !== 32'h8C090004) begin tests_failed++; $display("[TB] FAIL basic_w1: got %h/%h want 4/8c090004", wa0[1], wd0[1]); end
        tests_run++; if (wl0 !== 16'd2) begin tests_failed++; $display("[TB] FAIL basic_words: got %0d want 2", wl0); end
        tests_run++; if (crst0 !== 1'b0 || err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_cpu_rst_err: got %b%b want 00", crst0, err0); end
        tests_run++; if (done_cyc0 != last_we0 + 1) begin tests_failed++; $display("[TB] FAIL basic_done_lat: got cycle %0d want %0d", done_cyc0, last_we0 + 1); end
        tests_run++; if (done_cyc0 - start_cyc != 12) begin tests_failed++; $display("[TB] FAIL basic_load_time: got %0d want 12", done_cyc0 - start_cyc); end
    endtask

    task automatic test_random_valid();
        do_reset0();
        load_basic();
        drive_stream(1'b1, 300, left);
        wait_done("rand");
        tests_run++; if (wa0.size() != 2) begin tests_failed++; $display("[TB] FAIL rand_nwrites: got %0d want 2", wa0.size()); end
        tests_run++; if (wa0[0] !== 32'h0 || wd0[0] !== 32'h20080005) begin tests_failed++; $display("[TB] FAIL rand_w0: got %h/%h want 0/20080005", wa0[0], wd0[0]); end
        tests_run++; if (wa0[1] !== 32'h4 || wd0[1] !== 32'h8C090004) begin tests_failed++; $display("[TB] FAIL rand_w1: got %h/%h want 4/8c090004", wa0[1], wd0[1]); end
        tests_run++; if (offered == 0) begin tests_failed++; $display("[TB] FAIL rand_offer_in_write: got %0d offers want >0", offered); end
        tests_run++; if (bad_ready != 0) begin tests_failed++; $display("[TB] FAIL rand_ready_in_write: got %0d want 0", bad_ready); end
        tests_run++; if (wl0 !== 16'd2) begin tests_failed++; $display("[TB] FAIL rand_words: got %0d want 2", wl0); end
    endtask

    task automatic test_zero_len();
        do_reset0();
        stream = '{8'h00, 8'h00};
        drive_stream(1'b0, 20, left);
        tests_run++; if (done0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_done: got %b want 1", done0); end
        tests_run++; if (crst0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_cpu_rst: got %b want 0", crst0); end
        tb_valid = 1'b1;
        tb_data  = 8'h55;
        repeat (4) step();
        tb_valid = 1'b0;
        tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_ready: got %b want 0", rdy0); end
        tests_run++; if (wa0.size() != 0 || wl0 !== 16'd0) begin tests_failed++; $display("[TB] FAIL zero_nowrite: got %0d writes, words %0d want 0", wa0.size(), wl0); end
        tests_run++; if (done0 !== 1'b1 || err0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_terminal: got %b%b want 10", done0, err0); end
    endtask

    task automatic test_err();
        do_reset0();
        stream = '{8'h04, 8'h00};
        drive_stream(1'b0, 20, left);
        step();
        tests_run++; if (err0 !== 1'b0 || rdy0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL max_accepted: got err %b ready %b want 0 1", err0, rdy0); end
        do_reset0();
        stream = '{8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        drive_stream(1'b0, 12, left);
        tests_run++; if (left != 4) begin tests_failed++; $display("[TB] FAIL err_bytes_left: got %0d want 4", left); end
        tests_run++; if (err0 !== 1'b1 || rdy0 !== 1'b0 || crst0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_flags: got err %b ready %b cpu_rst %b want 1 0 1", err0, rdy0, crst0); end
        tests_run++; if (wa0.size() != 0 || done0 !== 1'b0 || both_bad != 0) begin tests_failed++; $display("[TB] FAIL err_nowrite: got %0d writes done %b both %0d want 0 0 0", wa0.size(), done0, both_bad); end
    endtask

    task automatic test_mid_reset();
        do_reset0();
        stream = '{8'h00, 8'h02, 8'hAA, 8'hBB};
        drive_stream(1'b0, 20, left);
        rst0 = 1'b1;
        step();
        tests_run++; if (rdy0 !== 1'b0 || we0 !== 1'b0 || crst0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_outputs: got ready %b we %b cpu_rst %b want 0 0 1", rdy0, we0, crst0); end
        rst0 = 1'b0;
        step();
        tests_run++; if (wa0.size() != 0 || wl0 !== 16'd0) begin tests_failed++; $display("[TB] FAIL midrst_partial: got %0d writes words %0d want 0 0", wa0.size(), wl0); end
        clear_log();
        load_basic();
        drive_stream(1'b0, 200, left);
        wait_done("midrst");
        tests_run++; if (wa0.size() != 2 || wa0[0] !== 32'h0 || wd0[0] !== 32'h20080005) begin tests_failed++; $display("[TB] FAIL midrst_reload_w0: got n=%0d %h/%h want 2 0/20080005", wa0.size(), wa0[0], wd0[0]); end
        tests_run++; if (wa0[1] !== 32'h4 || wd0[1] !== 32'h8C090004) begin tests_failed++; $display("[TB] FAIL midrst_reload_w1: got %h/%h want 4/8c090004", wa0[1], wd0[1]); end
    endtask

    task automatic test_base_adr();
        sel = 1'b1;
        rst1 = 1'b0;
        clear_log();
        stream = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'hA0, 8'hB0, 8'hC0, 8'hD0};
        drive_stream(1'b0, 200, left);
        wait_done("base");
        tests_run++; if (wa1.size() != 3) begin tests_failed++; $display("[TB] FAIL base_nwrites: got %0d want 3", wa1.size()); end
        tests_run++; if (wa1[0] !== 32'h100 || wa1[1] !== 32'h104 || wa1[2] !== 32'h108) begin tests_failed++; $display("[TB] FAIL base_addrs: got %h %h %h want 100 104 108", wa1[0], wa1[1], wa1[2]); end
        tests_run++; if (wdat1 !== 32'hA0B0C0D0) begin tests_failed++; $display("[TB] FAIL base_last_word: got %h want a0b0c0d0", wdat1); end
        tests_run++; if (done_cyc1 - start_cyc != 17) begin tests_failed++; $display("[TB] FAIL base_load_time: got %0d want 17", done_cyc1 - start_cyc); end
        tests_run++; if (wl1 !== 16'd3 || crst1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL base_final: got words %0d cpu_rst %b want 3 0", wl1, crst1); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_valid();
        test_zero_len();
        test_err();
        test_mid_reset();
        test_base_adr();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
